// File: rtl/frog_gate_collision_pkg.sv
// Shared definitions for the frog/gate collision detector and the game-logic FSMs.
// Holds the detector state encoding and the default post-report cooldown length.
package frog_gate_collision_pkg;

    typedef enum logic {
        ARMED    = 1'b0,
        COOLDOWN = 1'b1
    } coll_state_e;

    localparam int COOLDOWN_FRAMES_DEFAULT = 30;

endpackage

// File: rtl/frog_gate_collision.sv
// Per-frame frog/gate overlap detector: reports last frame's collisions as pulses one cycle after SOF.
// Latency 1 cycle from the SOF edge; no handshake or backpressure, consumers sample pulses when high.
module frog_gate_collision
    import frog_gate_collision_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEFAULT,
    parameter int CNT_W           = 8
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             startOfFrame,
    input  logic             frog_draw_req,
    input  logic             gateA_draw_req,
    input  logic             gateB_draw_req,
    output logic             collision_A,
    output logic             collision_B,
    output logic             frog_hit,
    output logic [CNT_W-1:0] hit_count,
    output logic             armed
);

    localparam int CD_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES - 1);

    coll_state_e      state_q, state_d;
    logic             acc_a_q, acc_a_d;
    logic             acc_b_q, acc_b_d;
    logic [CD_W-1:0]  cd_cnt_q, cd_cnt_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic             col_a_q, col_a_d;
    logic             col_b_q, col_b_d;
    logic             hit_q, hit_d;

    logic coin_a, coin_b, report;

    assign coin_a = frog_draw_req & gateA_draw_req;
    assign coin_b = frog_draw_req & gateB_draw_req;
    assign report = startOfFrame && (state_q == ARMED) && (acc_a_q || acc_b_q);

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q     <= ARMED;
            acc_a_q     <= 1'b0;
            acc_b_q     <= 1'b0;
            cd_cnt_q    <= '0;
            hit_count_q <= '0;
            col_a_q     <= 1'b0;
            col_b_q     <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            cd_cnt_q    <= cd_cnt_d;
            hit_count_q <= hit_count_d;
            col_a_q     <= col_a_d;
            col_b_q     <= col_b_d;
            hit_q       <= hit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cd_cnt_d = cd_cnt_q;
        if (startOfFrame) begin
            unique case (state_q)
                ARMED: begin
                    if (acc_a_q || acc_b_q) begin
                        state_d  = COOLDOWN;
                        cd_cnt_d = CD_LOAD;
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt_q == '0) begin
                        state_d = ARMED;
                    end else begin
                        cd_cnt_d = cd_cnt_q - 1'b1;
                    end
                end
                default: state_d = ARMED;
            endcase
        end
    end

    always_comb begin
        // SOF starts the new frame's accumulation with its own coincidence
        acc_a_d     = startOfFrame ? coin_a : (acc_a_q | coin_a);
        acc_b_d     = startOfFrame ? coin_b : (acc_b_q | coin_b);
        col_a_d     = report & acc_a_q;
        col_b_d     = report & acc_b_q;
        hit_d       = report;
        hit_count_d = hit_count_q;
        if (report && (hit_count_q != {CNT_W{1'b1}})) begin
            hit_count_d = hit_count_q + 1'b1;
        end
    end

    assign collision_A = col_a_q;
    assign collision_B = col_b_q;
    assign frog_hit    = hit_q;
    assign hit_count   = hit_count_q;
    assign armed       = (state_q == ARMED);

endmodule

// File: tb/tb_frog_gate_collision.sv
// Directed bench for frog_gate_collision with COOLDOWN_FRAMES=2, CNT_W=8.
module tb_frog_gate_collision;

    logic       CLK;
    logic       RESETn;
    logic       startOfFrame;
    logic       frog_draw_req;
    logic       gateA_draw_req;
    logic       gateB_draw_req;
    logic       collision_A;
    logic       collision_B;
    logic       frog_hit;
    logic [7:0] hit_count;
    logic       armed;

    int n_checks = 0;
    int n_fail   = 0;

    frog_gate_collision #(
        .COOLDOWN_FRAMES(2),
        .CNT_W          (8)
    ) dut (
        .CLK           (CLK),
        .RESETn        (RESETn),
        .startOfFrame  (startOfFrame),
        .frog_draw_req (frog_draw_req),
        .gateA_draw_req(gateA_draw_req),
        .gateB_draw_req(gateB_draw_req),
        .collision_A   (collision_A),
        .collision_B   (collision_B),
        .frog_hit      (frog_hit),
        .hit_count     (hit_count),
        .armed         (armed)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic overlap(input logic a, input logic b, input int n);
        frog_draw_req  = 1'b1;
        gateA_draw_req = a;
        gateB_draw_req = b;
        repeat (n) tick();
        frog_draw_req  = 1'b0;
        gateA_draw_req = 1'b0;
        gateB_draw_req = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic a, input logic b,
                             input logic [7:0] cnt, input logic arm);
        check({tag, "_colA"},  collision_A, a);
        check({tag, "_colB"},  collision_B, b);
        check({tag, "_hit"},   frog_hit,    a | b);
        check({tag, "_count"}, hit_count,   cnt);
        check({tag, "_armed"}, armed,       arm);
    endtask

    // One A-only report followed by the two ignored frames; ends ARMED
    task automatic report_cycle();
        tick();
        overlap(1'b1, 1'b0, 1);
        sof();
        tick();
        sof();
        tick();
        sof();
    endtask

    initial begin
        RESETn         = 1'b0;
        startOfFrame   = 1'b0;
        frog_draw_req  = 1'b0;
        gateA_draw_req = 1'b0;
        gateB_draw_req = 1'b0;
        repeat (3) tick();
        check_out("reset", 1'b0, 1'b0, 8'd0, 1'b1);
        RESETn = 1'b1;

        // Empty frame
        repeat (4) tick();
        sof();
        check_out("empty_sof", 1'b0, 1'b0, 8'd0, 1'b1);

        // Gate A overlap for 5 cycles
        tick();
        overlap(1'b1, 1'b0, 5);
        repeat (2) tick();
        sof();
        check_out("a_sof", 1'b1, 1'b0, 8'd1, 1'b0);
        tick();
        check_out("a_after", 1'b0, 1'b0, 8'd1, 1'b0);

        // Two ignored frames, then armed again
        repeat (2) tick();
        sof();
        check_out("cd1", 1'b0, 1'b0, 8'd1, 1'b0);
        repeat (2) tick();
        sof();
        check_out("cd2", 1'b0, 1'b0, 8'd1, 1'b1);

        // Both gates in one frame
        tick();
        overlap(1'b1, 1'b1, 3);
        tick();
        sof();
        check_out("ab_sof", 1'b1, 1'b1, 8'd2, 1'b0);
        tick();
        check_out("ab_after", 1'b0, 1'b0, 8'd2, 1'b0);

        // Overlaps during cooldown are discarded
        overlap(1'b1, 1'b1, 2);
        sof();
        check_out("ign1", 1'b0, 1'b0, 8'd2, 1'b0);
        overlap(1'b1, 1'b1, 2);
        sof();
        check_out("ign2", 1'b0, 1'b0, 8'd2, 1'b1);
        overlap(1'b1, 1'b0, 2);
        sof();
        check_out("third", 1'b1, 1'b0, 8'd3, 1'b0);

        // Wait out cooldown with empty frames
        tick();
        sof();
        tick();
        sof();
        check_out("rearm", 1'b0, 1'b0, 8'd3, 1'b1);

        // Coincidence only on the SOF cycle belongs to the new frame
        tick();
        startOfFrame   = 1'b1;
        frog_draw_req  = 1'b1;
        gateB_draw_req = 1'b1;
        tick();
        startOfFrame   = 1'b0;
        frog_draw_req  = 1'b0;
        gateB_draw_req = 1'b0;
        check_out("sof_coin", 1'b0, 1'b0, 8'd3, 1'b1);
        repeat (3) tick();
        sof();
        check_out("sof_coin_next", 1'b0, 1'b1, 8'd4, 1'b0);
        tick();
        sof();
        tick();
        sof();
        check_out("rearm2", 1'b0, 1'b0, 8'd4, 1'b1);

        // Drive hit_count to saturation
        for (int i = 0; i < 251; i++) report_cycle();
        check_out("preload", 1'b0, 1'b0, 8'd255, 1'b1);
        tick();
        overlap(1'b1, 1'b0, 1);
        sof();
        check_out("sat", 1'b1, 1'b0, 8'd255, 1'b0);
        tick();
        check_out("sat_after", 1'b0, 1'b0, 8'd255, 1'b0);

        // Reset with SOF and coincidence on the same edge, mid-cooldown
        RESETn         = 1'b0;
        startOfFrame   = 1'b1;
        frog_draw_req  = 1'b1;
        gateA_draw_req = 1'b1;
        tick();
        startOfFrame   = 1'b0;
        frog_draw_req  = 1'b0;
        gateA_draw_req = 1'b0;
        check_out("rst_cd", 1'b0, 1'b0, 8'd0, 1'b1);
        RESETn = 1'b1;
        tick();
        check_out("rst_cd_next", 1'b0, 1'b0, 8'd0, 1'b1);
        sof();
        check_out("rst_empty_sof", 1'b0, 1'b0, 8'd0, 1'b1);
        overlap(1'b0, 1'b1, 2);
        sof();
        check_out("post_rst_rpt", 1'b0, 1'b1, 8'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
